dsa_reg_bridge: RTL and testbench
=================================

# dsa_reg_bridge

System-clock register and memory-access engine for the bilinear DSA. It takes register requests that have already been synchronised into `clk_sys`, for example from the vJTAG front end. It exports the core configuration, a start pulse, status and performance counters. It also provides byte-streaming access with auto-increment to `NMEM` on-chip memories, each with its own pointer, configurable read latency and a sticky error flag.

## Interface
Parameters:
- `NMEM`, 2: number of memory banks, 1..8. Bank b owns register addresses 0x20+0x10·b (pointer) and 0x21+0x10·b (data).
- `AW`, 12: memory address width.
- `DEPTH`, 4096: valid locations per bank, at most 2^AW.
- `RD_LAT`, 1: memory read latency in cycles, 1..4.
- `START_CYCLES`, 8: width of the start pulse in cycles, 1..15.
- `DEF_W`, 64: reset value of `cfg_in_w`.
- `DEF_H`, 64: reset value of `cfg_in_h`.
- `DEF_SCALE`, 205: reset value of `cfg_scale_q88` (Q8.8).

Ports (one clock; reset is asynchronous and active-low):
- `clk_sys` in 1: system clock.
- `rst_sys_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 8: register address.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_rdata` out 32: read data (0 for writes).
- `start_pulse` out 1: start to the core.
- `cfg_in_w` out 16: input width.
- `cfg_in_h` out 16: input height.
- `cfg_scale_q88` out 16: quantised scale.
- `status_done` in 1: core done.
- `status_busy` in 1: core busy.
- `perf_flops` in 32, `perf_mem_rd` in 32, `perf_mem_wr` in 32: core counters.
- `mem_addr` out NMEM·AW: per-bank address.
- `mem_we` out NMEM: per-bank write enable.
- `mem_re` out NMEM: per-bank read enable.
- `mem_wdata` out NMEM·8: per-bank write byte.
- `mem_rdata` in NMEM·8: per-bank read byte, valid RD_LAT cycles after `mem_re`.

## Operation
Register map:
- 0x00 CONTROL (write-only):
  - bit0 = start.
  - bit1 = clear error.
- 0x01 IN_W and 0x02 IN_H (read/write): stored as 32 bits, the low 16 bits are exported.
- 0x03 SCALE (read/write): each write is quantised before it is stored:
  - Clamp to [128, 256].
  - k = (v − 128 + 6) / 13, saturating at 10.
  - Store 128 + 13k.
- 0x10 STATUS (read-only): {29'b0, err, busy, done}.
- 0x11, 0x12, 0x13 (read-only): `perf_flops`, `perf_mem_rd`, `perf_mem_wr`, each registered.
- 0x14 PROGRESS (read-only): equals `perf_mem_wr`.
- Bank PTR (read/write):
  - A write loads the pointer with `req_wdata[AW-1:0]`.
  - If `req_wdata` ≥ DEPTH, the pointer is set to 0 and err is set.
  - A read returns the pointer.
- Bank DATA write: drives a one-cycle `mem_we` at the pointer with `req_wdata[7:0]`, then pointer+1.
- Bank DATA read: drives a one-cycle `mem_re` at the pointer, returns {24'b0, byte}, then pointer+1.
- Pointer wrap: DEPTH−1 → 0. No error is raised on wrap.

Error rule: err is set by any of the following and is cleared only by CONTROL bit1:
- Access to an unmapped address, or to a bank index ≥ NMEM. The access has no side effect; a read returns 0xDEADBEEF.
- A write to a read-only address.
- A start request while `status_busy` = 1. The start is ignored.

Start:
- Loads a counter with START_CYCLES; `start_pulse` = (counter ≠ 0).
- A new accepted start during an active pulse reloads the counter to the full width.
- If bit0 and bit1 are written together, the error is cleared first, then the start is evaluated.

FSM:
- IDLE: `req_ready` = 1.
  - Register access → RESP.
  - DATA read → MRD.
- MRD: waits RD_LAT cycles, then captures `mem_rdata`, then → RESP.
- RESP: drives `rsp_valid` = 1 for exactly one cycle, then → IDLE.

Reset values:
- `req_ready` = 1.
- `rsp_valid` = 0; `rsp_rdata` = 0.
- `start_pulse` = 0.
- cfg = DEF_W / DEF_H / DEF_SCALE.
- `mem_we`, `mem_re`, `mem_addr` and `mem_wdata` = 0.
- All pointers = 0; err = 0.

Reset mid-operation: an asynchronous reset aborts MRD or RESP; no response is emitted.

## Timing
- A request is accepted at cycle T when `req_valid` && `req_ready`. `req_ready` goes low at T+1 and stays low until the cycle after `rsp_valid`.
- Register read/write: the register updates at T+1, and `rsp_valid` is high at T+1.
- DATA write:
  - `mem_we`, `mem_addr` and `mem_wdata` at T+1.
  - Pointer increments at T+1.
  - `rsp_valid` at T+1.
- DATA read:
  - `mem_re` and `mem_addr` at T+1.
  - Pointer increments at T+1.
  - Data is captured at T+1+RD_LAT.
  - `rsp_valid` at T+2+RD_LAT.
- Back-to-back throughput:
  - Register access: one request every 2 cycles.
  - DATA read: one request every RD_LAT+3 cycles.
- Start: `start_pulse` is high from T+1 through T+START_CYCLES.
- STATUS and perf registers sample their inputs every cycle (1-cycle lag).

## Test plan
- Reset, then read 0x01/0x02/0x03/0x10 → responses 64, 64, 205, 0; `start_pulse` = 0.
- Write SCALE with 100, 256, 300 and 200 in turn → read-back after each gives 128, 258→capped at 128+130 = 258? No: k saturates at 10, so 256 reads back as 258, 300 as 258, and 200 as 206.
- NMEM=2, RD_LAT=2:
  - Write PTR1 = 4094, then DATA1 writes 0xA1, 0xA2, 0xA3 → `mem_we`[1] at addresses 4094, 4095, 0.
  - Then write PTR1 = 4094 and do three DATA1 reads → responses 0xA1, 0xA2, 0xA3, each `rsp_valid` at T+4.
- Write CONTROL = 1 with `status_busy` = 0 → `start_pulse` high for 8 cycles. A second start at pulse cycle 5 → pulse stays high for 8 cycles from the reload.
- Error path:
  - Start with `status_busy` = 1 → no pulse, STATUS = 0x6 (err | busy).
  - Read 0x55 → 0xDEADBEEF.
  - Write PTR0 = 5000 → pointer 0.
  - Write CONTROL = 2 → STATUS bit2 = 0.
- Assert `rst_sys_n` during MRD → no `rsp_valid`; all outputs at their reset values; the next read of PTR0 returns 0.

Source files
------------

// File: rtl/dsa_reg_bridge.sv
// dsa_reg_bridge: clk_sys register/memory bridge for the bilinear DSA core.
// Decodes single-beat register requests, exports config and start, and streams bytes to NMEM banks.
module dsa_reg_bridge #(
  parameter int NMEM         = 2,
  parameter int AW           = 12,
  parameter int DEPTH        = 4096,
  parameter int RD_LAT       = 1,
  parameter int START_CYCLES = 8,
  parameter int DEF_W        = 64,
  parameter int DEF_H        = 64,
  parameter int DEF_SCALE    = 205
) (
  input  logic               clk_sys,
  input  logic               rst_sys_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [7:0]         req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               start_pulse,
  output logic [15:0]        cfg_in_w,
  output logic [15:0]        cfg_in_h,
  output logic [15:0]        cfg_scale_q88,
  input  logic               status_done,
  input  logic               status_busy,
  input  logic [31:0]        perf_flops,
  input  logic [31:0]        perf_mem_rd,
  input  logic [31:0]        perf_mem_wr,
  output logic [NMEM*AW-1:0] mem_addr,
  output logic [NMEM-1:0]    mem_we,
  output logic [NMEM-1:0]    mem_re,
  output logic [NMEM*8-1:0]  mem_wdata,
  input  logic [NMEM*8-1:0]  mem_rdata
);

  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_MRD   = 2'd1;
  localparam logic [1:0]    ST_RESP  = 2'd2;
  localparam logic [3:0]    BANK_LO  = 4'd2;
  localparam logic [3:0]    BANK_HI  = 4'(NMEM + 2);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);

  // Snap a requested scale onto the 13-step grid 128..258.
  function automatic logic [31:0] quant_scale(input logic [31:0] v);
    logic [31:0] c;
    logic [31:0] k;
    c = (v < 32'd128) ? 32'd128 : ((v > 32'd256) ? 32'd256 : v);
    k = (c - 32'd122) / 32'd13;
    if (k > 32'd10) k = 32'd10;
    else            k = k;
    return 32'd128 + k * 32'd13;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  logic [1:0]    state_r;
  logic [2:0]    lat_cnt_r;
  logic [2:0]    rd_bank_r;
  logic          req_ready_r, rsp_valid_r, err_r, done_r, busy_r, start_pulse_r;
  logic [31:0]   rsp_rdata_r, in_w_r, in_h_r, scale_r;
  logic [31:0]   flops_r, mem_rd_r, mem_wr_r;
  logic [3:0]    start_cnt_r;
  logic [AW-1:0] ptr_r [NMEM];
  logic [NMEM*AW-1:0] mem_addr_r;
  logic [NMEM-1:0]    mem_we_r, mem_re_r;
  logic [NMEM*8-1:0]  mem_wdata_r;

  logic          acc_s, in_bank_s, is_ptr_s, is_data_s, map_err_s, ro_s, ctrl_wr_s;
  logic          start_ok_s, err_set_s, err_clr_s, ptr_wr_s, dat_wr_s, dat_rd_s;
  logic [3:0]    hi_s;
  logic [2:0]    bank_s;
  logic [AW-1:0] sel_ptr_s;
  logic [31:0]   rd_data_s;
  logic [7:0]    rd_byte_s;

  // Request decode, read mux and error classification.
  always_comb begin
    acc_s     = req_valid && req_ready_r && (state_r == ST_IDLE);
    hi_s      = req_addr[7:4];
    bank_s    = 3'(hi_s - BANK_LO);
    in_bank_s = (hi_s >= BANK_LO) && (hi_s < BANK_HI);
    is_ptr_s  = in_bank_s && (req_addr[3:0] == 4'h0);
    is_data_s = in_bank_s && (req_addr[3:0] == 4'h1);
    sel_ptr_s = '0;
    rd_byte_s = 8'd0;
    for (int b = 0; b < NMEM; b++) begin
      sel_ptr_s = (bank_s == 3'(b)) ? ptr_r[b] : sel_ptr_s;
      rd_byte_s = (rd_bank_r == 3'(b)) ? mem_rdata[b*8 +: 8] : rd_byte_s;
    end
    rd_data_s = 32'd0;
    map_err_s = 1'b0;
    case (req_addr)
      8'h00: rd_data_s = 32'd0;
      8'h01: rd_data_s = in_w_r;
      8'h02: rd_data_s = in_h_r;
      8'h03: rd_data_s = scale_r;
      8'h10: rd_data_s = {29'd0, err_r, busy_r, done_r};
      8'h11: rd_data_s = flops_r;
      8'h12: rd_data_s = mem_rd_r;
      8'h13: rd_data_s = mem_wr_r;
      8'h14: rd_data_s = mem_wr_r;
      default: begin
        if (is_ptr_s) begin
          rd_data_s = {{(32-AW){1'b0}}, sel_ptr_s};
        end else if (is_data_s) begin
          rd_data_s = 32'd0;
        end else begin
          rd_data_s = 32'hDEAD_BEEF;
          map_err_s = 1'b1;
        end
      end
    endcase
    ro_s       = (req_addr >= 8'h10) && (req_addr <= 8'h14);
    ctrl_wr_s  = acc_s && req_write && (req_addr == 8'h00);
    ptr_wr_s   = acc_s && req_write && is_ptr_s;
    dat_wr_s   = acc_s && req_write && is_data_s;
    dat_rd_s   = acc_s && !req_write && is_data_s;
    start_ok_s = ctrl_wr_s && req_wdata[0] && !status_busy;
    err_clr_s  = ctrl_wr_s && req_wdata[1];
    // Set terms win over clear so a combined clear+start can re-flag a busy core.
    err_set_s  = (acc_s && (map_err_s || (req_write && ro_s)))
               || (ctrl_wr_s && req_wdata[0] && status_busy)
               || (ptr_wr_s && (req_wdata >= DEPTH_W));
  end

  // Request FSM, config/status registers, bank pointers and memory strobes.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_r     <= ST_IDLE;
      lat_cnt_r   <= 3'd0;
      rd_bank_r   <= 3'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      in_w_r      <= 32'(DEF_W);
      in_h_r      <= 32'(DEF_H);
      scale_r     <= 32'(DEF_SCALE);
      err_r       <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      flops_r     <= 32'd0;
      mem_rd_r    <= 32'd0;
      mem_wr_r    <= 32'd0;
      mem_addr_r  <= '0;
      mem_we_r    <= '0;
      mem_re_r    <= '0;
      mem_wdata_r <= '0;
      for (int b = 0; b < NMEM; b++) ptr_r[b] <= '0;
    end else begin
      mem_we_r    <= '0;
      mem_re_r    <= '0;
      rsp_valid_r <= 1'b0;
      done_r      <= status_done;
      busy_r      <= status_busy;
      flops_r     <= perf_flops;
      mem_rd_r    <= perf_mem_rd;
      mem_wr_r    <= perf_mem_wr;
      err_r       <= (err_r && !err_clr_s) || err_set_s;
      if (acc_s && req_write) begin
        case (req_addr)
          8'h01:   in_w_r  <= req_wdata;
          8'h02:   in_h_r  <= req_wdata;
          8'h03:   scale_r <= quant_scale(req_wdata);
          default: scale_r <= scale_r;
        endcase
      end
      for (int b = 0; b < NMEM; b++) begin
        if (bank_s == 3'(b)) begin
          if (ptr_wr_s) begin
            ptr_r[b] <= (req_wdata >= DEPTH_W) ? '0 : req_wdata[AW-1:0];
          end else if (dat_wr_s || dat_rd_s) begin
            ptr_r[b]                <= ptr_inc(ptr_r[b]);
            mem_addr_r[b*AW +: AW]  <= ptr_r[b];
            mem_we_r[b]             <= dat_wr_s;
            mem_re_r[b]             <= dat_rd_s;
            if (dat_wr_s) mem_wdata_r[b*8 +: 8] <= req_wdata[7:0];
          end
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (acc_s) begin
            req_ready_r <= 1'b0;
            if (dat_rd_s) begin
              state_r   <= ST_MRD;
              lat_cnt_r <= 3'(RD_LAT);
              rd_bank_r <= bank_s;
            end else begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= req_write ? 32'd0 : rd_data_s;
            end
          end
        end
        ST_MRD: begin
          // One extra cycle beyond RD_LAT: the strobe cycle itself, then the latency.
          if (lat_cnt_r == 3'd0) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= {24'd0, rd_byte_s};
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Start pulse stretcher; every accepted start reloads the full width.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      start_cnt_r   <= 4'd0;
      start_pulse_r <= 1'b0;
    end else if (start_ok_s) begin
      start_cnt_r   <= 4'(START_CYCLES);
      start_pulse_r <= 1'b1;
    end else if (start_cnt_r != 4'd0) begin
      start_cnt_r   <= start_cnt_r - 4'd1;
      start_pulse_r <= (start_cnt_r != 4'd1);
    end else begin
      start_cnt_r   <= 4'd0;
      start_pulse_r <= 1'b0;
    end
  end

  assign req_ready     = req_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign start_pulse   = start_pulse_r;
  assign cfg_in_w      = in_w_r[15:0];
  assign cfg_in_h      = in_h_r[15:0];
  assign cfg_scale_q88 = scale_r[15:0];
  assign mem_addr      = mem_addr_r;
  assign mem_we        = mem_we_r;
  assign mem_re        = mem_re_r;
  assign mem_wdata     = mem_wdata_r;

endmodule

// File: tb/tb_dsa_reg_bridge.sv
// Scoreboard bench for dsa_reg_bridge (NMEM=2, RD_LAT=2) with a behavioural two-bank byte memory.
module tb_dsa_reg_bridge;
  localparam int NMEM = 2;
  localparam int AW   = 12;

  logic               clk_sys = 1'b0;
  logic               rst_sys_n = 1'b0;
  logic               req_valid = 1'b0, req_write = 1'b0;
  logic [7:0]         req_addr = 8'd0;
  logic [31:0]        req_wdata = 32'd0;
  logic               req_ready, rsp_valid, start_pulse;
  logic [31:0]        rsp_rdata;
  logic [15:0]        cfg_in_w, cfg_in_h, cfg_scale_q88;
  logic               status_done = 1'b0, status_busy = 1'b0;
  logic [31:0]        perf_flops = 32'd0, perf_mem_rd = 32'd0, perf_mem_wr = 32'd0;
  logic [NMEM*AW-1:0] mem_addr;
  logic [NMEM-1:0]    mem_we, mem_re;
  logic [NMEM*8-1:0]  mem_wdata, mem_rdata;

  always #5 clk_sys = ~clk_sys;

  dsa_reg_bridge #(
    .NMEM(NMEM), .AW(AW), .DEPTH(4096), .RD_LAT(2), .START_CYCLES(8),
    .DEF_W(64), .DEF_H(64), .DEF_SCALE(205)
  ) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .start_pulse(start_pulse),
    .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
    .status_done(status_done), .status_busy(status_busy),
    .perf_flops(perf_flops), .perf_mem_rd(perf_mem_rd), .perf_mem_wr(perf_mem_wr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Two-stage read pipeline memory model: data appears two cycles after mem_re.
  logic [7:0] mem_arr [NMEM][4096];
  logic [7:0] st1 [NMEM];
  logic [7:0] st2 [NMEM];
  always @(posedge clk_sys) begin
    for (int b = 0; b < NMEM; b++) begin
      if (mem_we[b]) mem_arr[b][mem_addr[b*AW +: AW]] <= mem_wdata[b*8 +: 8];
      if (mem_re[b]) st1[b] <= mem_arr[b][mem_addr[b*AW +: AW]];
      st2[b] <= st1[b];
    end
  end
  assign mem_rdata = {st2[1], st2[0]};

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] we_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] mask;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest queued expectation.
  always @(negedge clk_sys) begin : mon
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got 0x%08h expected no response", rsp_rdata);
      end else begin
        e = sb.pop_front();
        check(e.name, rsp_rdata, e.data);
        check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  always @(negedge clk_sys) if (mem_we[1]) we_log.push_back({mem_addr[2*AW-1:AW], mem_wdata[15:8]});

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input int lat, input bit track);
    int   k;
    exp_t e;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    if (req_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got req_ready=%0b expected 1 within 50 cycles", req_ready);
    end else begin
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk_sys);
      #1;
      req_valid = 1'b0;
      if (track) begin
        e.data = exp;
        e.lat  = lat;
        e.acc  = cyc;
        e.name = $sformatf("%s_%02h", w ? "wr" : "rd", a);
        sb.push_back(e);
      end
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    issue(1'b0, a, 32'd0, exp, 0, 1'b1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    issue(1'b1, a, d, 32'd0, 0, 1'b1);
  endtask

  task automatic mrd(input logic [7:0] a, input logic [31:0] exp);
    issue(1'b0, a, 32'd0, exp, 3, 1'b1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    @(negedge clk_sys);
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_start"}, 32'(start_pulse), 32'd0);
    check({tag, "_cfg_w"}, 32'(cfg_in_w), 32'd64);
    check({tag, "_cfg_h"}, 32'(cfg_in_h), 32'd64);
    check({tag, "_cfg_scale"}, 32'(cfg_scale_q88), 32'd205);
    check({tag, "_mem_strobes"}, 32'({mem_we, mem_re}), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    check_reset_outputs("rst");
    rst_sys_n = 1'b1;
    @(negedge clk_sys);

    rd(8'h01, 32'd64);
    rd(8'h02, 32'd64);
    rd(8'h03, 32'd205);
    rd(8'h10, 32'd0);
    check("idle_start", 32'(start_pulse), 32'd0);

    // Scale quantisation: clamp low, saturate high, mid-grid.
    wr(8'h03, 32'd100);  rd(8'h03, 32'd128);
    wr(8'h03, 32'd256);  rd(8'h03, 32'd258);
    wr(8'h03, 32'd300);  rd(8'h03, 32'd258);
    wr(8'h03, 32'd200);  rd(8'h03, 32'd206);
    wr(8'h01, 32'h0001_2345); rd(8'h01, 32'h0001_2345);
    drain();
    check("cfg_scale_206", 32'(cfg_scale_q88), 32'd206);
    check("cfg_in_w_low16", 32'(cfg_in_w), 32'h0000_2345);

    // Bank 1 writes across the pointer wrap.
    wr(8'h30, 32'd4094); rd(8'h30, 32'd4094);
    wr(8'h31, 32'h0000_00A1);
    wr(8'h31, 32'h0000_00A2);
    wr(8'h31, 32'h0000_00A3);
    rd(8'h30, 32'd1);
    drain();
    check("we_log_count", 32'(we_log.size()), 32'd3);
    if (we_log.size() == 3) begin
      check("we0", 32'(we_log[0]), {12'd0, 12'd4094, 8'hA1});
      check("we1", 32'(we_log[1]), {12'd0, 12'd4095, 8'hA2});
      check("we2", 32'(we_log[2]), {12'd0, 12'd0,    8'hA3});
    end

    wr(8'h30, 32'd4094);
    mrd(8'h31, 32'h0000_00A1);
    mrd(8'h31, 32'h0000_00A2);
    mrd(8'h31, 32'h0000_00A3);
    wr(8'h20, 32'd0);
    wr(8'h21, 32'h0000_005C);
    wr(8'h20, 32'd0);
    mrd(8'h21, 32'h0000_005C);
    rd(8'h20, 32'd1);
    drain();

    // Start pulse: eight cycles, then a reload at pulse cycle 5.
    wr(8'h00, 32'd1);
    mask = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      mask[i] = start_pulse;
    end
    check("start_width", mask, 32'h0000_00FF);
    wr(8'h00, 32'd1);
    mask = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      mask[i] = start_pulse;
    end
    check("start_first_part", mask, 32'h0000_001F);
    wr(8'h00, 32'd1);
    mask = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      mask[i] = start_pulse;
    end
    check("start_reload", mask, 32'h0000_00FF);
    drain();

    // Error path.
    status_busy = 1'b1;
    repeat (2) @(negedge clk_sys);
    wr(8'h00, 32'd1);
    mask = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      mask[i] = start_pulse;
    end
    check("start_while_busy", mask, 32'd0);
    rd(8'h10, 32'h0000_0006);
    rd(8'h55, 32'hDEAD_BEEF);
    wr(8'h20, 32'd5000);
    rd(8'h20, 32'd0);
    wr(8'h00, 32'd2);
    rd(8'h10, 32'h0000_0002);
    drain();
    status_busy = 1'b0;
    status_done = 1'b1;
    perf_flops  = 32'h1111_2222;
    perf_mem_rd = 32'h3333_4444;
    perf_mem_wr = 32'h5555_6666;
    repeat (2) @(negedge clk_sys);
    rd(8'h10, 32'h0000_0001);
    rd(8'h11, 32'h1111_2222);
    rd(8'h12, 32'h3333_4444);
    rd(8'h13, 32'h5555_6666);
    rd(8'h14, 32'h5555_6666);
    wr(8'h11, 32'd5);
    rd(8'h10, 32'h0000_0005);
    wr(8'h00, 32'd3);
    @(negedge clk_sys);
    check("clear_then_start", 32'(start_pulse), 32'd1);
    rd(8'h10, 32'h0000_0001);
    drain();
    repeat (10) @(negedge clk_sys);

    // Asynchronous reset while a bank read is in flight.
    status_done = 1'b0;
    wr(8'h20, 32'd7);
    rd(8'h20, 32'd7);
    drain();
    issue(1'b0, 8'h21, 32'd0, 32'd0, 0, 1'b0);
    @(negedge clk_sys);
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    check_reset_outputs("midrst");
    repeat (4) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    rd(8'h20, 32'd0);
    rd(8'h03, 32'd205);
    rd(8'h01, 32'd64);
    rd(8'h10, 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
